mem_stage: RTL

Memory-access stage of the 5-stage pipeline CPU, sitting directly after the EX/MEM pipeline register and feeding the write-back stage. It performs data-memory loads and stores over a req/ack handshake with a variable-latency data memory. While an access is outstanding it stalls the upstream pipeline. It resolves branch/jump redirection from the EX/MEM flags and owns the MEM/WB pipeline register.

---
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bundle between the MEM stage and data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: drives loads and stores to a variable-latency
// data memory, stalls upstream while an access is outstanding, resolves
// branch/jump redirection and owns the MEM/WB register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; a memory op here is latched and launched
// REQ   | dmem_req high, waiting for dmem_ack or for the timeout to expire
// DONE  | access finished; MEM/WB takes the held entry at the next edge
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        beq_bne_in,
  input  logic        zero_in_1,
  input  logic        zero_in_2,
  input  logic        jump_in,
  input  logic [31:0] b_address_in,
  input  logic [31:0] j_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  rfile_wn_in,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic [1:0]  pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic [1:0]  wb_out,
  output logic [31:0] mem_rdata_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rfile_wn_out,
  output logic        mem_err
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   cap_data;
  logic          memop;
  logic          taken;

  assign memop = memread_in | memwrite_in;
  assign stall = ((state == IDLE) && memop) || (state == REQ);
  assign taken = branch_in & (beq_bne_in ? zero_in_2 : zero_in_1);
  assign flush = (pc_src != 2'b00);
  assign pc_target = (pc_src == 2'b10) ? j_in : b_address_in;

  // Redirect select; suppressed while the stage is stalled so a held branch
  // is not resolved twice.
  always_comb begin
    pc_src = 2'b00;
    if (!stall) begin
      if (jump_in)
        pc_src = 2'b10;
      else if (taken)
        pc_src = 2'b01;
    end
  end

  // Access sequencer: launches the request, waits on ack with a down-counting
  // timeout (terminal count 0), captures read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      cap_data        <= '0;
      mem_err         <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            dmem.dmem_addr  <= {alu_result_in[31:2], 2'b00};
            dmem.dmem_wdata <= rd2_in;
            dmem.dmem_we    <= memwrite_in;
            dmem.dmem_req   <= 1'b1;
            tmo_cnt         <= TMO_LOAD;
            state           <= REQ;
          end
        end
        REQ: begin
          if (dmem.dmem_ack) begin
            // A store has no read data to return.
            cap_data      <= dmem.dmem_we ? 32'd0 : dmem.dmem_rdata;
            dmem.dmem_req <= 1'b0;
            state         <= DONE;
          end else if (tmo_cnt == '0) begin
            mem_err       <= 1'b1;
            cap_data      <= 32'd0;
            dmem.dmem_req <= 1'b0;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, completed access from DONE,
  // plain pass-through for non-memory ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_out         <= 2'b00;
      mem_rdata_out  <= '0;
      alu_result_out <= '0;
      rfile_wn_out   <= '0;
    end else if (stall) begin
      wb_out       <= 2'b00;
      rfile_wn_out <= '0;
    end else begin
      wb_out         <= wb_in;
      alu_result_out <= alu_result_in;
      rfile_wn_out   <= rfile_wn_in;
      mem_rdata_out  <= (state == DONE) ? cap_data : 32'd0;
    end
  end

endmodule
